// File: rtl/des_iter_core.sv
// des_iter_core: iterative DES cipher, ROUNDS_PER_CYCLE Feistel rounds per clock, subkeys generated on the fly.
// Optional feature macro: DES_ITER_DECRYPT_EN builds the decrypt mode flag and right-rotate key schedule.
module des_iter_core #(
   parameter int ROUNDS_PER_CYCLE = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [63:0] in_data,
   input  logic [63:0] in_key,
   input  logic        in_decrypt,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_data,
   output logic        busy
);

   if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2 && ROUNDS_PER_CYCLE != 4 &&
       ROUNDS_PER_CYCLE != 8 && ROUNDS_PER_CYCLE != 16) begin : g_bad_rpc
      $error("des_iter_core: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
   end

   // Permutation tables hold 1-based FIPS bit numbers, bit 1 being the MSB
   localparam int IP_T [64] = '{58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
                                62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
                                57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
                                61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
   localparam int FP_T [64] = '{40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
                                38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
                                36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
                                34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};
   localparam int E_T [48] = '{32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
                                8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
                               16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
                               24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
   localparam int P_T [32] = '{16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
                                2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
   localparam int PC1_T [56] = '{57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
                                 10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
                                 63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
                                 14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
   localparam int PC2_T [48] = '{14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
                                 23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
                                 41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                                 44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
   // S-boxes flattened row-major: index = {b1, b6, b2..b5}
   localparam int SBOX [8][64] = '{
      '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
         0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
         4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
        15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13},
      '{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
         3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
         0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
        13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9},
      '{10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
        13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
        13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
         1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12},
      '{ 7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
        13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
        10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
         3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14},
      '{ 2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
        14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
         4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
        11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3},
      '{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
        10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
         9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
         4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13},
      '{ 4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
        13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
         1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
         6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12},
      '{13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
         1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
         7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
         2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11}};

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t      state_q, state_d;
   logic [31:0] l_q, l_d, r_q, r_d, l_rnd, r_rnd;
   logic [27:0] c_q, c_d, d_q, d_d, c_rnd, d_rnd;
   logic [4:0]  round_q, round_d;
   logic [63:0] out_q, out_d;
`ifdef DES_ITER_DECRYPT_EN
   logic        dec_q, dec_d;
`else
   logic        unused_decrypt;
   assign unused_decrypt = in_decrypt;
`endif

   function automatic logic [63:0] ip(input logic [63:0] x);
      ip = '0;
      for (int i = 0; i < 64; i++) ip[63-i] = x[64-IP_T[i]];
   endfunction

   function automatic logic [63:0] fp(input logic [63:0] x);
      fp = '0;
      for (int i = 0; i < 64; i++) fp[63-i] = x[64-FP_T[i]];
   endfunction

   function automatic logic [55:0] pc1(input logic [63:0] k);
      pc1 = '0;
      for (int i = 0; i < 56; i++) pc1[55-i] = k[64-PC1_T[i]];
   endfunction

   function automatic logic [47:0] pc2(input logic [55:0] cd);
      pc2 = '0;
      for (int i = 0; i < 48; i++) pc2[47-i] = cd[56-PC2_T[i]];
   endfunction

   function automatic logic [27:0] rol28(input logic [27:0] x, input logic one);
      return one ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
   endfunction

`ifdef DES_ITER_DECRYPT_EN
   function automatic logic [27:0] ror28(input logic [27:0] x, input logic one);
      return one ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
   endfunction
`endif

   function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] k);
      logic [47:0] x;
      logic [31:0] s;
      logic [5:0]  six;
      x = '0;
      s = '0;
      for (int i = 0; i < 48; i++) x[47-i] = r[32-E_T[i]];
      x = x ^ k;
      for (int b = 0; b < 8; b++) begin
         six = x[47-6*b -: 6];
         s[31-4*b -: 4] = 4'(SBOX[b][{six[5], six[0], six[4:1]}]);
      end
      feistel = '0;
      for (int i = 0; i < 32; i++) feistel[31-i] = s[32-P_T[i]];
   endfunction

   // Apply ROUNDS_PER_CYCLE rounds, rotating C/D before each round to form its subkey
   always_comb begin
      logic [31:0] t;
      logic [4:0]  rnd;
      logic        one;
      l_rnd = l_q;
      r_rnd = r_q;
      c_rnd = c_q;
      d_rnd = d_q;
      t = '0;
      rnd = '0;
      one = 1'b0;
      for (int j = 0; j < ROUNDS_PER_CYCLE; j++) begin
         rnd = round_q + 5'(j) + 5'd1;
`ifdef DES_ITER_DECRYPT_EN
         if (dec_q) begin
            one = (rnd == 5'd2) || (rnd == 5'd9) || (rnd == 5'd16);
            c_rnd = (rnd == 5'd1) ? c_rnd : ror28(c_rnd, one);
            d_rnd = (rnd == 5'd1) ? d_rnd : ror28(d_rnd, one);
         end else begin
            one = (rnd == 5'd1) || (rnd == 5'd2) || (rnd == 5'd9) || (rnd == 5'd16);
            c_rnd = rol28(c_rnd, one);
            d_rnd = rol28(d_rnd, one);
         end
`else
         one = (rnd == 5'd1) || (rnd == 5'd2) || (rnd == 5'd9) || (rnd == 5'd16);
         c_rnd = rol28(c_rnd, one);
         d_rnd = rol28(d_rnd, one);
`endif
         t = r_rnd;
         r_rnd = l_rnd ^ feistel(r_rnd, pc2({c_rnd, d_rnd}));
         l_rnd = t;
      end
   end

   // Next-state logic: accept in IDLE, iterate in RUN, hold the result in DONE
   always_comb begin
      state_d = state_q;
      l_d = l_q;
      r_d = r_q;
      c_d = c_q;
      d_d = d_q;
      round_d = round_q;
      out_d = out_q;
`ifdef DES_ITER_DECRYPT_EN
      dec_d = dec_q;
`endif
      case (state_q)
         IDLE: if (in_valid) begin
            state_d = RUN;
            {l_d, r_d} = ip(in_data);
            {c_d, d_d} = pc1(in_key);
            round_d = '0;
`ifdef DES_ITER_DECRYPT_EN
            dec_d = in_decrypt;
`endif
         end
         RUN: begin
            l_d = l_rnd;
            r_d = r_rnd;
            c_d = c_rnd;
            d_d = d_rnd;
            round_d = round_q + 5'(ROUNDS_PER_CYCLE);
            if (round_d == 5'd16) begin
               state_d = DONE;
               out_d = fp({r_rnd, l_rnd});
            end
         end
         DONE: if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset aborts any block in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         l_q <= '0;
         r_q <= '0;
         c_q <= '0;
         d_q <= '0;
         round_q <= '0;
         out_q <= '0;
`ifdef DES_ITER_DECRYPT_EN
         dec_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         l_q <= l_d;
         r_q <= r_d;
         c_q <= c_d;
         d_q <= d_d;
         round_q <= round_d;
         out_q <= out_d;
`ifdef DES_ITER_DECRYPT_EN
         dec_q <= dec_d;
`endif
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q == RUN);
   assign out_data  = out_q;

endmodule

// File: tb/tb_des_iter_core.sv
// tb_des_iter_core: directed DES vectors on cores built with 1, 4 and 16 rounds per cycle.
module tb_des_iter_core;

   localparam int RPC [3] = '{1, 4, 16};
   localparam logic [63:0] K1 = 64'h133457799BBCDFF1;
   localparam logic [63:0] P1 = 64'h0123456789ABCDEF;
   localparam logic [63:0] C1 = 64'h85E813540F0AB405;
   localparam logic [63:0] K2 = 64'h0E329232EA6D0D73;
   localparam logic [63:0] P2 = 64'h8787878787878787;
   localparam logic [63:0] C2 = 64'h0000000000000000;
   localparam logic [63:0] KP = 64'h123457799BBCDFF0;

   typedef struct {
      int          sel;
      logic        dec;
      logic [63:0] key;
      logic [63:0] data;
      logic [63:0] exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [2:0]  iv = '0;
   logic [63:0] in_data = '0;
   logic [63:0] in_key = '0;
   logic        in_decrypt = 1'b0;
   logic        out_ready = 1'b0;
   wire  [2:0]  ir, ov, bz;
   wire  [63:0] od [3];
   int          n_cmp = 0;
   int          n_bad = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      des_iter_core #(.ROUNDS_PER_CYCLE(RPC[g])) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_valid  (iv[g]),
         .in_ready  (ir[g]),
         .in_data   (in_data),
         .in_key    (in_key),
         .in_decrypt(in_decrypt),
         .out_valid (ov[g]),
         .out_ready (out_ready),
         .out_data  (od[g]),
         .busy      (bz[g])
      );
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic run_vec(input int sel, input logic dec, input logic [63:0] key,
                          input logic [63:0] data, input logic [63:0] exp, input string name);
      int   cyc;
      logic bz_ok;
      @(negedge clk);
      in_key = key;
      in_data = data;
      in_decrypt = dec;
      out_ready = 1'b1;
      iv[sel] = 1'b1;
      @(posedge clk);
      #1;
      iv[sel] = 1'b0;
      cyc = 0;
      bz_ok = 1'b1;
      while (!ov[sel] && cyc < 40) begin
         bz_ok = bz_ok & bz[sel] & ~ir[sel];
         @(posedge clk);
         #1;
         cyc++;
      end
      check({name, " latency"}, 64'(cyc), 64'(16 / RPC[sel]));
      check({name, " busy"}, {63'd0, bz_ok}, 64'd1);
      check({name, " data"}, od[sel], exp);
      @(posedge clk);
      #1;
      check({name, " release"}, {61'd0, ov[sel], ir[sel], bz[sel]}, 64'b010);
   endtask

   initial begin
      vec_t vecs[$];
      int   cyc;
      logic ok;
      vecs.push_back('{0, 1'b0, K1, P1, C1});
      vecs.push_back('{0, 1'b0, K2, P2, C2});
      vecs.push_back('{1, 1'b0, K2, P2, C2});
      vecs.push_back('{2, 1'b0, K2, P2, C2});
      vecs.push_back('{1, 1'b0, K1, P1, C1});
      vecs.push_back('{2, 1'b0, K1, P1, C1});
      vecs.push_back('{0, 1'b0, KP, P1, C1});
      vecs.push_back('{2, 1'b0, KP, P1, C1});
`ifdef DES_ITER_DECRYPT_EN
      vecs.push_back('{0, 1'b1, K1, C1, P1});
      vecs.push_back('{1, 1'b1, K2, C2, P2});
      vecs.push_back('{2, 1'b1, K1, C1, P1});
      vecs.push_back('{0, 1'b1, K2, C2, P2});
`endif

      #2;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("reset flags %0d", i), {61'd0, ir[i], ov[i], bz[i]}, 64'b100);
         check($sformatf("reset data %0d", i), od[i], 64'd0);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++)
         run_vec(vecs[i].sel, vecs[i].dec, vecs[i].key, vecs[i].data, vecs[i].exp,
                 $sformatf("vec%0d", i));

      // back-pressure: result held while a second block waits with changing data
      @(negedge clk);
      in_key = K1;
      in_data = P1;
      in_decrypt = 1'b0;
      out_ready = 1'b0;
      iv[0] = 1'b1;
      @(posedge clk);
      #1;
      cyc = 0;
      while (!ov[0] && cyc < 40) begin
         @(negedge clk);
         in_data = {$urandom, $urandom};
         in_key = {$urandom, $urandom};
         @(posedge clk);
         #1;
         cyc++;
      end
      check("stall latency", 64'(cyc), 64'd16);
      ok = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         in_data = {$urandom, $urandom};
         @(posedge clk);
         #1;
         check($sformatf("stall hold %0d", i), od[0], C1);
         ok = ok & ov[0] & ~ir[0] & ~bz[0];
      end
      check("stall flags", {63'd0, ok}, 64'd1);
      @(negedge clk);
      in_data = P2;
      in_key = K2;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("stall handshake", {62'd0, ov[0], ir[0]}, 64'b01);
      @(posedge clk);
      #1;
      iv[0] = 1'b0;
      check("second accepted", {62'd0, ir[0], bz[0]}, 64'b01);
      cyc = 0;
      while (!ov[0] && cyc < 40) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      check("second latency", 64'(cyc), 64'd16);
      check("second data", od[0], C2);
      @(posedge clk);
      #1;

      // reset during round 7 discards the block
      run_vec(0, 1'b0, K1, P1, C1, "pre-reset");
      @(negedge clk);
      in_key = K2;
      in_data = P2;
      iv[0] = 1'b1;
      @(posedge clk);
      #1;
      iv[0] = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      check("mid-run busy", {63'd0, bz[0]}, 64'd1);
      rst_n = 1'b0;
      #1;
      check("abort flags", {61'd0, ir[0], ov[0], bz[0]}, 64'b100);
      check("abort data", od[0], 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      ok = 1'b1;
      repeat (20) begin
         @(posedge clk);
         #1;
         ok = ok & ~ov[0] & ir[0];
      end
      check("no output after abort", {63'd0, ok}, 64'd1);
      run_vec(0, 1'b0, K1, P1, C1, "post-reset");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
